param_sweep_sched: RTL
======================

# param_sweep_sched

Sequencer and arbiter for the oscillator parameter register file (NUMOSCS × NUMPARAMS 32-bit words). On every sample tick it streams all parameters, oscillator by oscillator, to the FM engine. It also shares the file's single access slot with a host write port. Host writes land only between oscillators, so the engine never sees a half-updated parameter set for any oscillator. It sits between the host/bus bridge and the parameter register file, and feeds the oscillator engine.

## Interface
- NUMOSCS, 12, number of oscillators
- NUMPARAMS, 24, parameters per oscillator
- OSCW, 4, oscillator index width (≥ clog2(NUMOSCS))
- PRMW, 5, parameter index width (≥ clog2(NUMPARAMS))

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- sample_tick  in  1  one-cycle pulse: start a full sweep
- host_req  in  1  host write request; hold with addr/data until host_ack
- host_osc  in  OSCW  target oscillator
- host_param  in  PRMW  target parameter
- host_wdata  in  32  write data
- host_ack  out  1  one-cycle pulse: request consumed
- host_err  out  1  pulse with host_ack when the address is out of range
- rf_rden  out  1  register file read strobe
- rf_wren  out  1  register file write strobe
- rf_osc  out  OSCW  access oscillator index
- rf_param  out  PRMW  access parameter index
- rf_wdata  out  32  write data
- rf_rdata  in  32  read data, valid the cycle after rf_rden
- eng_valid  out  1  eng_* fields valid
- eng_osc  out  OSCW  oscillator of eng_data
- eng_param  out  PRMW  parameter of eng_data
- eng_data  out  32  parameter value
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  pulse with the final eng_valid of a sweep
- overrun  out  1  pulse: sample_tick arrived while a sweep was pending or running

## Operation
- FSM states: IDLE, SWEEP, WRITE. Return target register `ret` ∈ {IDLE, SWEEP}. Counters `osc`, `prm`. Flag `tick_pend`.
- IDLE:
  - host_req → WRITE with ret = IDLE. A simultaneous sample_tick sets tick_pend.
  - Otherwise, sample_tick or tick_pend → SWEEP with osc = prm = 0. tick_pend is cleared.
- SWEEP: issue one read per cycle at (osc, prm).
  - prm increments each cycle.
  - At prm = NUMPARAMS−1, prm wraps to 0 and osc increments.
  - At osc = NUMOSCS−1, prm = NUMPARAMS−1, the sweep ends. Next state: WRITE (ret = IDLE) if host_req is high, else IDLE.
  - On any other oscillator's last parameter with host_req high → WRITE, ret = SWEEP. The counters have already advanced to the next oscillator.
- WRITE: exactly one cycle.
  - If host_osc < NUMOSCS and host_param < NUMPARAMS: rf_wren = 1, rf_osc/rf_param/rf_wdata = host fields.
  - Otherwise rf_wren = 0 and host_err = 1.
  - host_ack = 1 in both cases. Next state = ret.
- At most one host write is granted per oscillator boundary. A host_req still high the cycle after host_ack is a new request.
- sample_tick while sweep_busy or tick_pend: pulse overrun; the tick is dropped.
- rf_rden and rf_wren are never both 1.

## Timing
- Reset (reset_n low at a clk edge) takes effect at that edge, including mid-sweep or mid-write:
  - state = IDLE; counters and tick_pend cleared.
  - All outputs 0 from the following cycle. No eng_valid is emitted for an in-flight read.
- rf_* outputs are registered. A read issued in cycle N has eng_valid/eng_osc/eng_param/eng_data in cycle N+1; eng_data = rf_rdata unregistered-through.
- sweep_busy: high from the cycle after the accepting sample_tick through the cycle of the last rf_rden.
- Sweep with no writes: 288 read cycles at defaults. Each granted boundary write adds exactly 1 cycle.
- sample_tick in cycle N with IDLE and no host_req: first rf_rden in N+1, first eng_valid in N+2.
- host_req in IDLE in cycle N: rf_wren and host_ack in N+1.
- host_req during a sweep: worst-case wait NUMPARAMS+1 cycles.

## Test plan
- Single tick, no host traffic → 288 consecutive eng_valid with (osc, prm) in order 0/0 … 11/23; rf_rdata = {osc, prm} pattern echoed; sweep_done with 11/23; no gaps.
- host_req (osc 3, param 7, 0xDEADBEEF) in IDLE → rf_wren and host_ack one cycle later; the next sweep reads back 0xDEADBEEF at 3/7.
- host_req raised while osc 5 param 10 is read → write occurs after 5/23, before 6/0; total sweep 289 cycles; no eng_valid gap other than the 1 cycle.
- sample_tick during a sweep → overrun pulse, no second sweep; a tick and host_req in the same IDLE cycle → write first, then the sweep starts the next cycle.
- host_osc = 12 → host_ack and host_err pulse, rf_wren stays 0, register file unchanged.
- reset_n low at osc 7 → all outputs 0 next cycle, IDLE; a subsequent tick runs a full clean sweep from 0/0.

Source files
------------

// File: rtl/param_sweep_sched.sv
// -----------------------------------------------------------------------------
// param_sweep_sched
//
// Sequences reads of the oscillator parameter register file and shares its
// single access slot with a host write port.
//
// Each sample_tick starts a sweep. A sweep reads every parameter, one per
// cycle, oscillator by oscillator, and forwards each value to the FM engine.
// Host writes are granted only in IDLE or at an oscillator boundary. The
// engine therefore never sees one oscillator's parameter set half old and
// half new.
//
// Ports
//   clk, reset_n            clock; synchronous active-low reset
//   sample_tick             one-cycle pulse that requests a full sweep
//   host_req/osc/param/wdata  host write request, held until host_ack
//   host_ack, host_err      request consumed; error if the address is out of range
//   rf_rden, rf_wren        register file read/write strobes (registered)
//   rf_osc, rf_param        register file access address (registered)
//   rf_wdata                register file write data (registered)
//   rf_rdata                register file read data, valid the cycle after rf_rden
//   eng_valid/osc/param/data  parameter stream to the oscillator engine
//   sweep_busy              high from the first read to the last read of a sweep
//   sweep_done              pulses with the final eng_valid of a sweep
//   overrun                 pulses when a sample_tick is dropped
// -----------------------------------------------------------------------------
module param_sweep_sched #(
    parameter int NUMOSCS   = 12,
    parameter int NUMPARAMS = 24,
    parameter int OSCW      = 4,
    parameter int PRMW      = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sample_tick,
    input  logic            host_req,
    input  logic [OSCW-1:0] host_osc,
    input  logic [PRMW-1:0] host_param,
    input  logic [31:0]     host_wdata,
    output logic            host_ack,
    output logic            host_err,
    output logic            rf_rden,
    output logic            rf_wren,
    output logic [OSCW-1:0] rf_osc,
    output logic [PRMW-1:0] rf_param,
    output logic [31:0]     rf_wdata,
    input  logic [31:0]     rf_rdata,
    output logic            eng_valid,
    output logic [OSCW-1:0] eng_osc,
    output logic [PRMW-1:0] eng_param,
    output logic [31:0]     eng_data,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic            overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [OSCW-1:0] OSC_LAST = OSCW'(NUMOSCS - 1);
    localparam logic [PRMW-1:0] PRM_LAST = PRMW'(NUMPARAMS - 1);

    state_t          state, state_next;
    state_t          ret, ret_next;
    logic [OSCW-1:0] osc, osc_next;
    logic [PRMW-1:0] prm, prm_next;
    logic            tick_pend, tick_pend_next;

    // Registered-output next values, all derived from the next state.
    logic            rden_next;
    logic            wren_next;
    logic            ack_next;
    logic            err_next;
    logic            busy_next;
    logic            overrun_next;
    logic            last_read_next;
    logic [OSCW-1:0] rf_osc_next;
    logic [PRMW-1:0] rf_param_next;
    logic [31:0]     rf_wdata_next;

    // Marks the read in flight as the final one of the sweep, so that
    // sweep_done lines up with the matching eng_valid.
    logic            last_read;

    logic            busy;
    logic            host_ok;

    // Next-state logic. osc/prm always hold the address that the next SWEEP
    // cycle reads. A boundary write therefore resumes at the next oscillator
    // without further bookkeeping.
    always_comb begin
        state_next     = state;
        ret_next       = ret;
        osc_next       = osc;
        prm_next       = prm;
        tick_pend_next = tick_pend;

        // A sweep counts as running in a mid-sweep write cycle as well.
        // Ticks arriving then are dropped.
        busy         = (state == SWEEP) || ((state == WRITE) && (ret == SWEEP));
        overrun_next = sample_tick && (busy || tick_pend);
        host_ok      = (host_osc <= OSC_LAST) && (host_param <= PRM_LAST);

        case (state)
            IDLE: begin
                if (host_req) begin
                    state_next = WRITE;
                    ret_next   = IDLE;
                    if (sample_tick) begin
                        tick_pend_next = 1'b1;
                    end
                end else if (sample_tick || tick_pend) begin
                    state_next     = SWEEP;
                    osc_next       = '0;
                    prm_next       = '0;
                    tick_pend_next = 1'b0;
                end
            end

            SWEEP: begin
                if (prm == PRM_LAST) begin
                    prm_next = '0;
                    if (osc == OSC_LAST) begin
                        osc_next   = '0;
                        ret_next   = IDLE;
                        state_next = host_req ? WRITE : IDLE;
                    end else begin
                        osc_next = osc + 1'b1;
                        if (host_req) begin
                            state_next = WRITE;
                            ret_next   = SWEEP;
                        end
                    end
                end else begin
                    prm_next = prm + 1'b1;
                end
            end

            WRITE: begin
                // The host still holds host_req in the ack cycle. It is not
                // treated as a new request here.
                state_next = ret;
                if ((ret == IDLE) && sample_tick && !tick_pend) begin
                    tick_pend_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                ret_next   = IDLE;
            end
        endcase
    end

    // Decode the registered register-file and host-handshake outputs from
    // the state being entered. They then line up exactly with that state.
    always_comb begin
        rden_next      = 1'b0;
        wren_next      = 1'b0;
        ack_next       = 1'b0;
        err_next       = 1'b0;
        last_read_next = 1'b0;
        rf_osc_next    = '0;
        rf_param_next  = '0;
        rf_wdata_next  = '0;
        busy_next      = (state_next == SWEEP) ||
                         ((state_next == WRITE) && (ret_next == SWEEP));

        if (state_next == SWEEP) begin
            rden_next      = 1'b1;
            rf_osc_next    = osc_next;
            rf_param_next  = prm_next;
            last_read_next = (osc_next == OSC_LAST) && (prm_next == PRM_LAST);
        end else if (state_next == WRITE) begin
            ack_next = 1'b1;
            if (host_ok) begin
                wren_next     = 1'b1;
                rf_osc_next   = host_osc;
                rf_param_next = host_param;
                rf_wdata_next = host_wdata;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    // State, counters and registered outputs. Reset also clears the engine
    // stage, so a read that is in flight when reset hits is never forwarded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ret        <= IDLE;
            osc        <= '0;
            prm        <= '0;
            tick_pend  <= 1'b0;
            rf_rden    <= 1'b0;
            rf_wren    <= 1'b0;
            rf_osc     <= '0;
            rf_param   <= '0;
            rf_wdata   <= '0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            sweep_busy <= 1'b0;
            overrun    <= 1'b0;
            last_read  <= 1'b0;
            eng_valid  <= 1'b0;
            eng_osc    <= '0;
            eng_param  <= '0;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_next;
            ret        <= ret_next;
            osc        <= osc_next;
            prm        <= prm_next;
            tick_pend  <= tick_pend_next;
            rf_rden    <= rden_next;
            rf_wren    <= wren_next;
            rf_osc     <= rf_osc_next;
            rf_param   <= rf_param_next;
            rf_wdata   <= rf_wdata_next;
            host_ack   <= ack_next;
            host_err   <= err_next;
            sweep_busy <= busy_next;
            overrun    <= overrun_next;
            last_read  <= last_read_next;
            eng_valid  <= rf_rden;
            eng_osc    <= rf_rden ? rf_osc : '0;
            eng_param  <= rf_rden ? rf_param : '0;
            sweep_done <= rf_rden && last_read;
        end
    end

    // The register file returns data one cycle after the read strobe. The
    // data passes straight through to the engine, gated to zero when no
    // value is presented.
    assign eng_data = eng_valid ? rf_rdata : '0;

endmodule
